// File: rtl/alu_muldiv_seq_pkg.sv
// Shared definitions for the sequential M-extension multiply/divide unit:
// funct3 op codes, FSM state encoding and operand signedness decode.
package alu_muldiv_seq_pkg;

   localparam logic [2:0] F_MUL    = 3'b000;
   localparam logic [2:0] F_MULH   = 3'b001;
   localparam logic [2:0] F_MULHSU = 3'b010;
   localparam logic [2:0] F_MULHU  = 3'b011;
   localparam logic [2:0] F_DIV    = 3'b100;
   localparam logic [2:0] F_DIVU   = 3'b101;
   localparam logic [2:0] F_REM    = 3'b110;
   localparam logic [2:0] F_REMU   = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PREP = 3'd1,
      S_CALC = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } state_e;

   function automatic logic op_a_signed(input logic [2:0] f);
      return (f == F_MULH) || (f == F_MULHSU) || (f == F_DIV) || (f == F_REM);
   endfunction

   function automatic logic op_b_signed(input logic [2:0] f);
      return (f == F_MULH) || (f == F_DIV) || (f == F_REM);
   endfunction

endpackage

// File: rtl/alu_muldiv_seq_datapath.sv
// Iterative radix-2 datapath: operand latch, magnitude prep, shift-add multiply,
// restoring divide, sign fix-up and result register. Sequenced by alu_muldiv_seq.
module muldiv_datapath
   import alu_muldiv_seq_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN) + 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            capture_i,
   input  logic            prep_i,
   input  logic            step_i,
   input  logic            fix_i,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   output logic            cnt_done_o,
   output logic [XLEN-1:0] result_o
);

   logic [2:0]        op_q, op_d;
   logic [XLEN-1:0]   a_q, a_d, b_q, b_d, m_q, m_d, res_q, res_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic              neg_q, neg_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              is_div, a_neg, b_neg, div_ge;
   logic [XLEN-1:0]   mag_a, mag_b, lo, hi;
   logic [XLEN:0]     mul_sum, div_trial, div_rem;
   logic [2*XLEN-1:0] prod;

   always_comb begin
      op_d  = op_q;
      a_d   = a_q;
      b_d   = b_q;
      m_d   = m_q;
      res_d = res_q;
      acc_d = acc_q;
      neg_d = neg_q;
      cnt_d = cnt_q;

      is_div    = op_q[2];
      a_neg     = op_a_signed(op_q) & a_q[XLEN-1];
      b_neg     = op_b_signed(op_q) & b_q[XLEN-1];
      mag_a     = a_neg ? -a_q : a_q;
      mag_b     = b_neg ? -b_q : b_q;
      lo        = acc_q[XLEN-1:0];
      hi        = acc_q[2*XLEN-1:XLEN];
      mul_sum   = {1'b0, hi} + (acc_q[0] ? {1'b0, m_q} : '0);
      // Divide: hi holds the partial remainder, lo shifts dividend out / quotient in.
      div_trial = acc_q[2*XLEN-1:XLEN-1];
      div_ge    = div_trial >= {1'b0, m_q};
      div_rem   = div_ge ? (div_trial - {1'b0, m_q}) : div_trial;
      prod      = neg_q ? -acc_q : acc_q;

      if (capture_i) begin
         op_d = funct3_i;
         a_d  = rs1_i;
         b_d  = rs2_i;
      end
      if (prep_i) begin
         cnt_d = '0;
         if (is_div) begin
            m_d   = mag_b;
            acc_d = {{XLEN{1'b0}}, mag_a};
            // Divide-by-zero keeps an unsigned all-ones quotient.
            neg_d = op_q[1] ? a_neg : ((a_neg ^ b_neg) & (b_q != '0));
         end else begin
            m_d   = mag_a;
            acc_d = {{XLEN{1'b0}}, mag_b};
            neg_d = a_neg ^ b_neg;
         end
      end
      if (step_i) begin
         cnt_d = cnt_q + 1'b1;
         if (is_div) acc_d = {div_rem[XLEN-1:0], lo[XLEN-2:0], div_ge};
         else        acc_d = {mul_sum, lo[XLEN-1:1]};
      end
      if (fix_i) begin
         if (is_div) res_d = op_q[1] ? (neg_q ? -hi : hi) : (neg_q ? -lo : lo);
         else        res_d = (op_q == F_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         op_q  <= '0;
         a_q   <= '0;
         b_q   <= '0;
         m_q   <= '0;
         res_q <= '0;
         acc_q <= '0;
         neg_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         op_q  <= op_d;
         a_q   <= a_d;
         b_q   <= b_d;
         m_q   <= m_d;
         res_q <= res_d;
         acc_q <= acc_d;
         neg_q <= neg_d;
         cnt_q <= cnt_d;
      end
   end

   assign cnt_done_o = (cnt_q == CNT_W'(XLEN));
   assign result_o   = res_q;

endmodule

// File: rtl/alu_muldiv_seq.sv
// Sequential RISC-V M-extension multiply/divide unit: fixed-latency FSM
// (IDLE, PREP, CALC, FIX, DONE) driving the iterative muldiv_datapath.
module alu_muldiv_seq
   import alu_muldiv_seq_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN) + 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start_i,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);

   state_e state_q, state_d;
   logic   capture, prep, step, fix, cnt_done;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // CALC spends one extra cycle seeing the counter at XLEN, which keeps
   // the latency identical for every op.
   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      prep    = 1'b0;
      step    = 1'b0;
      fix     = 1'b0;
      case (state_q)
         S_IDLE: if (start_i) begin
            capture = 1'b1;
            state_d = S_PREP;
         end
         S_PREP: begin
            prep    = 1'b1;
            state_d = S_CALC;
         end
         S_CALC: begin
            if (cnt_done) state_d = S_FIX;
            else          step    = 1'b1;
         end
         S_FIX: begin
            fix     = 1'b1;
            state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign busy_o = (state_q != S_IDLE);
   assign done_o = (state_q == S_DONE);

   muldiv_datapath #(
      .XLEN  (XLEN),
      .CNT_W (CNT_W)
   ) u_dp (
      .clk        (clk),
      .reset      (reset),
      .capture_i  (capture),
      .prep_i     (prep),
      .step_i     (step),
      .fix_i      (fix),
      .funct3_i   (funct3_i),
      .rs1_i      (rs1_i),
      .rs2_i      (rs2_i),
      .cnt_done_o (cnt_done),
      .result_o   (result_o)
   );

endmodule
